// File: rtl/pcie_cfg_fc_regslice_pkg.sv
// pcie_cfg_fc_pkg: shared constants, state type and settle helpers for the cfg_fc register slice.
package pcie_cfg_fc_pkg;
   localparam int PIPE_MIN   = 0;
   localparam int PIPE_MAX   = 4;
   localparam int LAT_MIN    = 0;
   localparam int LAT_MAX    = 7;
   localparam int SETTLE_MAX = 16;
   localparam int CNT_W      = $clog2(SETTLE_MAX + 1);
   typedef enum logic {SETTLING, VALID} fc_state_e;
   // Round trip: SEL out through the pipe, core latency, credits back, plus the registered flag.
   function automatic int settle(input int pipe, input int lat);
      return 2 * pipe + lat + 1;
   endfunction
   function automatic int fw(input int w);
      return w > 0 ? w : 1;
   endfunction
endpackage

// File: rtl/pcie_cfg_fc_regslice_if.sv
// pcie_cfg_fc_regslice_if: credit/SEL bundle; master faces the PCIe core, slave faces the consumer.
interface pcie_cfg_fc_regslice_if
   import pcie_cfg_fc_pkg::*;
#(
   parameter int PH_W   = 8,
   parameter int PD_W   = 12,
   parameter int NPH_W  = 8,
   parameter int NPD_W  = 12,
   parameter int CPLH_W = 8,
   parameter int CPLD_W = 12,
   parameter int SEL_W  = 3
);
   logic [fw(PH_W)-1:0]   ph;
   logic [fw(PD_W)-1:0]   pd;
   logic [fw(NPH_W)-1:0]  nph;
   logic [fw(NPD_W)-1:0]  npd;
   logic [fw(CPLH_W)-1:0] cplh;
   logic [fw(CPLD_W)-1:0] cpld;
   logic [fw(SEL_W)-1:0]  sel;
   logic                  fc_valid;
   logic                  hold;
   modport master (output sel, input ph, pd, nph, npd, cplh, cpld);
   modport slave  (input sel, hold, output ph, pd, nph, npd, cplh, cpld, fc_valid);
endinterface

// File: rtl/pcie_cfg_fc_regslice_pipe.sv
// pcie_cfg_fc_pipe: W-bit, N-stage delay line with async active-low reset; N=0 is a wire.
module pcie_cfg_fc_pipe #(
   parameter int W = 1,
   parameter int N = 1
) (
   input  logic         aclk,
   input  logic         aresetn,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);
   if (N == 0) begin : g_wire
      assign q_o = d_i;
   end else begin : g_reg
      logic [W-1:0] stage_q [N];
      always_ff @(posedge aclk or negedge aresetn)
         if (!aresetn)
            for (int k = 0; k < N; k++) stage_q[k] <= '0;
         else begin
            stage_q[0] <= d_i;
            for (int k = 1; k < N; k++) stage_q[k] <= stage_q[k-1];
         end
      assign q_o = stage_q[N-1];
   end
endmodule

// File: rtl/pcie_cfg_fc_regslice.sv
// pcie_cfg_fc_regslice: pipelined cfg_fc passthrough with SEL settle tracking, valid flag and output hold.
module pcie_cfg_fc_regslice
   import pcie_cfg_fc_pkg::*;
#(
   parameter int C_PH_WIDTH    = 8,
   parameter int C_HAS_PH      = 1,
   parameter int C_PD_WIDTH    = 12,
   parameter int C_HAS_PD      = 1,
   parameter int C_NPH_WIDTH   = 8,
   parameter int C_HAS_NPH     = 1,
   parameter int C_NPD_WIDTH   = 12,
   parameter int C_HAS_NPD     = 1,
   parameter int C_CPLH_WIDTH  = 8,
   parameter int C_HAS_CPLH    = 1,
   parameter int C_CPLD_WIDTH  = 12,
   parameter int C_HAS_CPLD    = 1,
   parameter int C_SEL_WIDTH   = 3,
   parameter int C_PIPE_STAGES = 2,
   parameter int C_CORE_LAT    = 1
) (
   input logic aclk,
   input logic aresetn,
   pcie_cfg_fc_regslice_if.master s,
   pcie_cfg_fc_regslice_if.slave  m
);
   localparam int FW [6] = '{fw(C_PH_WIDTH), fw(C_PD_WIDTH), fw(C_NPH_WIDTH),
                             fw(C_NPD_WIDTH), fw(C_CPLH_WIDTH), fw(C_CPLD_WIDTH)};
   localparam int HAS [6] = '{C_HAS_PH, C_HAS_PD, C_HAS_NPH, C_HAS_NPD, C_HAS_CPLH, C_HAS_CPLD};
   localparam int SW = fw(C_SEL_WIDTH);
   localparam logic [CNT_W-1:0] SETTLE_V = CNT_W'(settle(C_PIPE_STAGES, C_CORE_LAT));
   function automatic int off(input int n);
      int o = 0;
      for (int j = 0; j < n; j++) o += FW[j];
      return o;
   endfunction
   localparam int TW = off(6);
   if (C_PIPE_STAGES < PIPE_MIN || C_PIPE_STAGES > PIPE_MAX ||
       C_CORE_LAT < LAT_MIN || C_CORE_LAT > LAT_MAX) begin : g_bad_param
      $error("pcie_cfg_fc_regslice: C_PIPE_STAGES or C_CORE_LAT out of range");
   end
   logic [TW-1:0] s_bus, m_bus;
   assign s_bus = {s.cpld, s.cplh, s.npd, s.nph, s.pd, s.ph};
   assign {m.cpld, m.cplh, m.npd, m.nph, m.pd, m.ph} = m_bus;
   for (genvar i = 0; i < 6; i++) begin : g_fld
      localparam int O = off(i);
      if (HAS[i] != 0) begin : g_on
         logic [FW[i]-1:0] p, hold_q;
         pcie_cfg_fc_pipe #(.W(FW[i]), .N(C_PIPE_STAGES)) u_pipe (
            .aclk(aclk), .aresetn(aresetn), .d_i(s_bus[O +: FW[i]]), .q_o(p));
         always_ff @(posedge aclk or negedge aresetn)
            if (!aresetn) hold_q <= '0;
            else hold_q <= m_bus[O +: FW[i]];
         assign m_bus[O +: FW[i]] = m.hold ? hold_q : p;
      end else begin : g_off
         assign m_bus[O +: FW[i]] = '0;
      end
   end
   pcie_cfg_fc_pipe #(.W(SW), .N(C_PIPE_STAGES)) u_sel_pipe (
      .aclk(aclk), .aresetn(aresetn), .d_i(m.sel), .q_o(s.sel));
   logic [SW-1:0]    prev_sel_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sel_chg, valid_q, vhold_q;
   fc_state_e        state_q;
   assign sel_chg = m.sel != prev_sel_q;
   assign cnt_d = sel_chg ? SETTLE_V : (cnt_q != '0 ? cnt_q - 1'b1 : cnt_q);
   assign m.fc_valid = m.hold ? vhold_q : valid_q;
   always_ff @(posedge aclk or negedge aresetn)
      if (!aresetn) begin
         prev_sel_q <= '0;
         cnt_q      <= SETTLE_V;
         vhold_q    <= 1'b0;
      end else begin
         prev_sel_q <= m.sel;
         cnt_q      <= cnt_d;
         vhold_q    <= m.fc_valid;
      end
   // Count reaching 1 with no fresh change means the round trip has fully drained.
   always_ff @(posedge aclk or negedge aresetn)
      if (!aresetn) begin
         state_q <= SETTLING;
         valid_q <= 1'b0;
      end else if (state_q == SETTLING) begin
         if (!sel_chg && cnt_q == CNT_W'(1)) begin
            state_q <= VALID;
            valid_q <= 1'b1;
         end
      end else if (sel_chg) begin
         state_q <= SETTLING;
         valid_q <= 1'b0;
      end
endmodule

// File: tb/tb_pcie_cfg_fc_regslice.sv
// tb_pcie_cfg_fc_regslice: scoreboard bench for a default slice and a 0-stage/0-latency slice without NPD.
module tb_pcie_cfg_fc_regslice;
   typedef struct packed {
      logic [11:0] cpld;
      logic [7:0]  cplh;
      logic [11:0] npd;
      logic [7:0]  nph;
      logic [11:0] pd;
      logic [7:0]  ph;
   } cr_t;
   typedef struct {
      int       k;
      logic [2:0] ssel;
      cr_t      m;
      logic     v;
   } exp_t;
   localparam int NN [2] = '{2, 0};
   localparam int LL [2] = '{1, 0};
   localparam int SS [2] = '{6, 1};
   logic clk = 1'b0;
   logic aresetn = 1'b0;
   always #5 clk = ~clk;
   pcie_cfg_fc_regslice_if s0 (), m0 (), s1 (), m1 ();
   pcie_cfg_fc_regslice u0 (.aclk(clk), .aresetn(aresetn), .s(s0), .m(m0));
   pcie_cfg_fc_regslice #(.C_PIPE_STAGES(0), .C_CORE_LAT(0), .C_HAS_NPD(0)) u1 (
      .aclk(clk), .aresetn(aresetn), .s(s1), .m(m1));
   cr_t        tbl [8];
   logic [2:0] selh [8];
   logic [2:0] sselh [2][8];
   cr_t        shist [2][8];
   cr_t        pm [2];
   logic       pv [2];
   int         age = 0;
   logic [2:0] prevsel = '0;
   exp_t       sbq [$];
   int         errs = 0;
   int         checks = 0;
   function automatic cr_t rnd_cr();
      return cr_t'({$urandom, $urandom});
   endfunction
   task automatic chk(input string n, input int k, input logic [63:0] g, input logic [63:0] x);
      checks++;
      if (g !== x) begin
         errs++;
         $display("FAIL %s[%0d] got %h expected %h at %0t", n, k, g, x, $time);
      end
   endtask
   task automatic drive(input int k, input cr_t c);
      if (k == 0) begin
         s0.ph = c.ph; s0.pd = c.pd; s0.nph = c.nph; s0.npd = c.npd; s0.cplh = c.cplh; s0.cpld = c.cpld;
      end else begin
         s1.ph = c.ph; s1.pd = c.pd; s1.nph = c.nph; s1.npd = c.npd; s1.cplh = c.cplh; s1.cpld = c.cpld;
      end
   endtask
   // Model: age = edges since the last observed SEL change (or reset release); valid once age >= settle.
   task automatic step(input logic [2:0] sel, input logic hold, input logic rn);
      logic re;
      exp_t e;
      cr_t  c;
      @(posedge clk);
      re = !aresetn;
      if (re) begin
         age = 0;
         prevsel = '0;
      end else begin
         age = (selh[0] != prevsel) ? 0 : (age < 1000 ? age + 1 : age);
         prevsel = selh[0];
      end
      #1;
      aresetn = rn;
      if (re || !rn) begin
         age = 0;
         prevsel = '0;
         for (int k = 0; k < 2; k++) begin
            pm[k] = '0;
            pv[k] = 1'b0;
         end
      end
      for (int d = 7; d > 0; d--) begin
         selh[d] = (re || !rn) ? 3'd0 : selh[d-1];
         for (int k = 0; k < 2; k++) begin
            sselh[k][d] = (re || !rn) ? 3'd0 : sselh[k][d-1];
            shist[k][d] = (re || !rn) ? cr_t'(0) : shist[k][d-1];
         end
      end
      selh[0] = sel;
      m0.sel = sel; m1.sel = sel;
      m0.hold = hold; m1.hold = hold;
      for (int k = 0; k < 2; k++) begin
         sselh[k][0] = selh[NN[k]];
         c = tbl[sselh[k][LL[k]]];
         shist[k][0] = c;
         drive(k, c);
         e.k = k;
         e.ssel = sselh[k][0];
         e.m = hold ? pm[k] : shist[k][NN[k]];
         if (k == 1) e.m.npd = '0;
         e.v = hold ? pv[k] : (age >= SS[k]);
         pm[k] = rn ? e.m : cr_t'(0);
         pv[k] = rn ? e.v : 1'b0;
         sbq.push_back(e);
      end
   endtask
   always @(negedge clk) begin
      exp_t e;
      cr_t  g;
      while (sbq.size() > 0) begin
         e = sbq.pop_front();
         g = (e.k == 0) ? cr_t'({m0.cpld, m0.cplh, m0.npd, m0.nph, m0.pd, m0.ph})
                        : cr_t'({m1.cpld, m1.cplh, m1.npd, m1.nph, m1.pd, m1.ph});
         chk("s_sel", e.k, 64'(e.k == 0 ? s0.sel : s1.sel), 64'(e.ssel));
         chk("m_credits", e.k, 64'(g), 64'(e.m));
         chk("m_fc_valid", e.k, 64'(e.k == 0 ? m0.fc_valid : m1.fc_valid), 64'(e.v));
      end
   end
   initial begin
      logic [2:0] sel;
      logic       hold;
      for (int i = 0; i < 8; i++) begin
         tbl[i] = rnd_cr();
         selh[i] = '0;
         for (int k = 0; k < 2; k++) begin
            sselh[k][i] = '0;
            shist[k][i] = '0;
         end
      end
      tbl[0].ph = 8'h40;
      tbl[3].pd = 12'h123;
      tbl[2].nph = 8'h10;
      pm = '{default: '0};
      pv = '{default: 1'b0};
      m0.sel = '0; m1.sel = '0; m0.hold = 1'b0; m1.hold = 1'b0;
      drive(0, '0);
      drive(1, '0);
      repeat (3) step(3'd0, 1'b0, 1'b0);
      repeat (10) step(3'd0, 1'b0, 1'b1);
      repeat (11) step(3'd3, 1'b0, 1'b1);
      step(3'd0, 1'b0, 1'b1);
      step(3'd1, 1'b0, 1'b1);
      repeat (11) step(3'd2, 1'b0, 1'b1);
      step(3'd2, 1'b1, 1'b1);
      tbl[2].nph = 8'h20;
      repeat (5) step(3'd2, 1'b1, 1'b1);
      repeat (5) step(3'd2, 1'b0, 1'b1);
      repeat (4) step(3'd5, 1'b1, 1'b1);
      repeat (10) step(3'd5, 1'b0, 1'b1);
      repeat (3) step(3'd6, 1'b0, 1'b1);
      repeat (2) step(3'd6, 1'b0, 1'b0);
      repeat (10) step(3'd6, 1'b0, 1'b1);
      sel = 3'd6;
      hold = 1'b0;
      repeat (400) begin
         if ($urandom_range(7) == 0) sel = 3'($urandom);
         if ($urandom_range(15) == 0) hold = !hold;
         if ($urandom_range(31) == 0) tbl[$urandom_range(7)] = rnd_cr();
         step(sel, hold, $urandom_range(99) != 0);
      end
      repeat (10) step(sel, 1'b0, 1'b1);
      @(negedge clk);
      #1;
      checks++;
      if (sbq.size() != 0) begin
         errs++;
         $display("FAIL scoreboard_drain got %0d pending expected 0", sbq.size());
      end
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
